// File: rtl/vga_scan_reader.sv
// vga_scan_reader: scans a 160x120 frame buffer (3-bit colour) and drives 640x480@60 VGA.
// Latency: DAC outputs show position P 2 clocks after the counters reach P; 1 pixel = 2 clocks.
// Backpressure: none; free-running raster. Memory must return rd_data within 2 clocks of rd_en.
//
// Ports:
//   CLOCK_50, reset        - system clock, asynchronous active-high reset
//   rd_addr, rd_en, rd_data - frame-buffer read port (addr = fb_y*160 + fb_x)
//   VGA_R/G/B              - 10-bit DAC colour, each bit replicates one colour bit
//   VGA_HS, VGA_VS         - active-low syncs; VGA_BLANK_N high while visible
//   VGA_SYNC_N             - tied 0; VGA_CLK - 25 MHz pixel clock (tick register)
//   frame_start            - one-clock pulse when the counters enter (0,0)
//
// Optional build macro VGA_SCAN_TEST_PATTERN_EN: replaces the frame-buffer
// read path with internally generated colour bars and a white border.

module vga_scan_reader #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int FB_WIDTH  = 160
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    output logic [14:0] rd_addr,
    output logic        rd_en,
    input  logic [2:0]  rd_data,
    output logic [9:0]  VGA_R,
    output logic [9:0]  VGA_G,
    output logic [9:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N,
    output logic        VGA_CLK,
    output logic        frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
    localparam logic [7:0] FB_COLS  = 8'(FB_WIDTH);

    logic       tick;
    logic [9:0] hcount;
    logic [9:0] vcount;
    logic [9:0] hnext;
    logic [9:0] vnext;
    logic       next_vis;
    logic       cur_vis;
    logic       cur_hs_n;
    logic       cur_vs_n;
    logic [2:0] colour_src;

    // Position the counters move to on the coming advance.
    always_comb begin
        hnext = hcount + 10'd1;
        vnext = vcount;
        if (hcount == H_LAST) begin
            hnext = 10'd0;
            vnext = (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
        end
    end

    // The column term only matters if H_VISIBLE is overridden past the
    // frame-buffer width; it keeps reads inside the buffer in that case.
    assign next_vis = (hnext < H_VIS) && (vnext < V_VIS) && (hnext[9:2] < FB_COLS);
    assign cur_vis  = (hcount < H_VIS) && (vcount < V_VIS);
    assign cur_hs_n = !((hcount >= HS_FIRST) && (hcount <= HS_LAST));
    assign cur_vs_n = !((vcount >= VS_FIRST) && (vcount <= VS_LAST));

`ifdef VGA_SCAN_TEST_PATTERN_EN
    localparam logic [7:0] FB_LAST_X = 8'(FB_WIDTH - 1);
    localparam logic [6:0] FB_LAST_Y = 7'(V_VISIBLE / 4 - 1);

    logic [7:0] fb_x_cur;
    logic [6:0] fb_y_cur;
    logic       border;
    logic       unused_rd_data;

    assign fb_x_cur       = hcount[9:2];
    assign fb_y_cur       = vcount[8:2];
    assign border         = (fb_x_cur == 8'd0) || (fb_x_cur == FB_LAST_X) ||
                            (fb_y_cur == 7'd0) || (fb_y_cur == FB_LAST_Y);
    // Generated from the position being displayed, so it lands in the same
    // clock a memory read for that position would have.
    assign colour_src     = border ? 3'b111 : fb_x_cur[5:3];
    assign unused_rd_data = ^rd_data;
`else
    logic [7:0]  fb_x_next;
    logic [6:0]  fb_y_next;
    logic [14:0] addr_next;

    assign fb_x_next  = hnext[9:2];
    assign fb_y_next  = vnext[8:2];
    // fb_y*160 as fb_y*128 + fb_y*32.
    assign addr_next  = {1'b0, fb_y_next, 7'b0} + {3'b0, fb_y_next, 5'b0} + {7'b0, fb_x_next};
    assign colour_src = rd_data;
`endif

    // The read for a position is issued on the advance that enters it; its
    // data is sampled on the following advance, together with the sync and
    // blank decoded from the same (now current) position.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            tick        <= 1'b0;
            hcount      <= 10'd0;
            vcount      <= 10'd0;
            rd_en       <= 1'b0;
            rd_addr     <= 15'd0;
            VGA_R       <= 10'd0;
            VGA_G       <= 10'd0;
            VGA_B       <= 10'd0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            tick        <= ~tick;
            rd_en       <= 1'b0;
            frame_start <= 1'b0;
            if (tick) begin
                hcount      <= hnext;
                vcount      <= vnext;
                frame_start <= (hnext == 10'd0) && (vnext == 10'd0);
`ifndef VGA_SCAN_TEST_PATTERN_EN
                if (next_vis) begin
                    rd_en   <= 1'b1;
                    rd_addr <= addr_next;
                end
`endif
                VGA_R       <= {10{cur_vis & colour_src[2]}};
                VGA_G       <= {10{cur_vis & colour_src[1]}};
                VGA_B       <= {10{cur_vis & colour_src[0]}};
                VGA_HS      <= cur_hs_n;
                VGA_VS      <= cur_vs_n;
                VGA_BLANK_N <= cur_vis;
            end
        end
    end

`ifdef VGA_SCAN_TEST_PATTERN_EN
    logic unused_next_vis;
    assign unused_next_vis = next_vis;
`endif

    assign VGA_CLK    = tick;
    assign VGA_SYNC_N = 1'b0;

endmodule

// File: tb/tb_vga_scan_reader.sv
// Directed bench: a full-size instance for line timing and colour checks, and
// a short-frame instance (8 visible lines) for frame-level timing. Time t is
// the number of rising edges since reset release; samples are on falling edges.
module tb_vga_scan_reader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #10 clk = ~clk;

    // full-size instance
    logic [14:0] d_addr;
    logic        d_en;
    logic [2:0]  d_data = 3'd0;
    logic [9:0]  d_r, d_g, d_b;
    logic        d_hs, d_vs, d_blank_n, d_sync_n, d_vclk, d_fs;

    // short-frame instance
    logic [14:0] s_addr;
    logic        s_en;
    logic [2:0]  s_data = 3'd0;
    logic [9:0]  s_r, s_g, s_b;
    logic        s_hs, s_vs, s_blank_n, s_sync_n, s_vclk, s_fs;

    vga_scan_reader dut (
        .CLOCK_50(clk), .reset(rst), .rd_addr(d_addr), .rd_en(d_en), .rd_data(d_data),
        .VGA_R(d_r), .VGA_G(d_g), .VGA_B(d_b), .VGA_HS(d_hs), .VGA_VS(d_vs),
        .VGA_BLANK_N(d_blank_n), .VGA_SYNC_N(d_sync_n), .VGA_CLK(d_vclk), .frame_start(d_fs)
    );

    vga_scan_reader #(.V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)) sdut (
        .CLOCK_50(clk), .reset(rst), .rd_addr(s_addr), .rd_en(s_en), .rd_data(s_data),
        .VGA_R(s_r), .VGA_G(s_g), .VGA_B(s_b), .VGA_HS(s_hs), .VGA_VS(s_vs),
        .VGA_BLANK_N(s_blank_n), .VGA_SYNC_N(s_sync_n), .VGA_CLK(s_vclk), .frame_start(s_fs)
    );

    // Memory models: return addr[2:0] one clock after the strobe (inside the 2-clock budget).
    logic force_white = 1'b0;
    always @(posedge clk) if (d_en) d_data <= force_white ? 3'b111 : d_addr[2:0];
    always @(posedge clk) if (s_en) s_data <= s_addr[2:0];

    int total = 0;
    int bad   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    localparam logic [29:0] WHITE = {10'h3FF, 10'h3FF, 10'h3FF};

    int  hs_fall1, hs_fall2, hs_rise1, blank_rise, blank_fall;
    int  vs_fall, vs_rise, fs_t1, fs_t2, fs_cnt, d_fs_cnt, d_vs_cnt;
    int  rd_line1, rd_frame, rd_any, white_cnt, dark_cnt;
    logic hs_d, blank_d, vs_d;

    initial begin
        hs_fall1 = -1; hs_fall2 = -1; hs_rise1 = -1; blank_rise = -1; blank_fall = -1;
        vs_fall = -1; vs_rise = -1; fs_t1 = -1; fs_t2 = -1;
        fs_cnt = 0; d_fs_cnt = 0; d_vs_cnt = 0;
        rd_line1 = 0; rd_frame = 0; rd_any = 0; white_cnt = 0; dark_cnt = 0;

        // Reset held for 5 clocks; outputs must sit at reset values.
        repeat (5) @(negedge clk);
        check_eq("rst_rgb",   {d_r, d_g, d_b}, 30'd0);
        check_eq("rst_syncs", {d_hs, d_vs, d_blank_n, d_sync_n}, 4'b1100);
        check_eq("rst_misc",  {d_vclk, d_fs, d_en, d_addr}, 18'd0);
        rst = 1'b0;
        check_eq("t0_vclk", d_vclk, 1'b0);
        hs_d = d_hs; blank_d = d_blank_n; vs_d = s_vs;

        for (int t = 1; t <= 44802; t++) begin
            @(negedge clk);
            if (t == 3000) force_white = 1'b1;

            if (t == 1) begin
                check_eq("t1_vclk",  d_vclk, 1'b1);
                check_eq("t1_blank", d_blank_n, 1'b0);
            end
            if (t == 2) check_eq("t2_vclk", d_vclk, 1'b0);

            // edge records
            if (!blank_d && d_blank_n && blank_rise < 0) blank_rise = t;
            if (blank_d && !d_blank_n && blank_fall < 0) blank_fall = t;
            if (hs_d && !d_hs) begin
                if (hs_fall1 < 0) hs_fall1 = t;
                else if (hs_fall2 < 0) hs_fall2 = t;
            end
            if (!hs_d && d_hs && hs_rise1 < 0) hs_rise1 = t;
            if (vs_d && !s_vs && vs_fall < 0) vs_fall = t;
            if (!vs_d && s_vs && vs_rise < 0) vs_rise = t;
            if (s_fs) begin
                fs_cnt++;
                if (fs_t1 < 0) fs_t1 = t; else if (fs_t2 < 0) fs_t2 = t;
            end
            if (d_fs) d_fs_cnt++;
            if (!d_vs) d_vs_cnt++;
            if (d_en) rd_any++;
            hs_d = d_hs; blank_d = d_blank_n; vs_d = s_vs;

`ifndef VGA_SCAN_TEST_PATTERN_EN
            if (t == 2) check_eq("t2_read0", {d_en, d_addr}, {1'b1, 15'd0});
            if (t == 8) check_eq("addr_4_0", {d_en, d_addr}, {1'b1, 15'd1});
            if (t == 10)   check_eq("col_4_0",   {d_r, d_g, d_b}, {10'h0, 10'h0, 10'h3FF});
            if (t == 1276) check_eq("col_637_0", {d_r, d_g, d_b}, WHITE);
            if (t == 1282) check_eq("col_640_0", {d_blank_n, d_r, d_g, d_b}, 31'd0);
            if (t >= 1600 && t <= 3199 && d_en) rd_line1++;
            if (t >= 3202 && t <= 4801) begin
                if (d_blank_n && {d_r, d_g, d_b} == WHITE) white_cnt++;
                if (!d_blank_n && {d_r, d_g, d_b} == 30'd0) dark_cnt++;
            end
            if (t == 12474) check_eq("addr_637_7",  {s_en, s_addr}, {1'b1, 15'd319});
            if (t == 12476) check_eq("col_637_7",   {s_r, s_g, s_b}, WHITE);
            if (t == 12480) check_eq("noread_640",  {s_en, s_addr}, {1'b0, 15'd319});
            if (t == 12482) check_eq("blank_640_7", {s_blank_n, s_r, s_g, s_b}, 31'd0);
            if (t == 22400) check_eq("wrap_read",   {s_fs, s_en, s_addr}, {2'b11, 15'd0});
            if (t >= 22400 && t <= 44799 && s_en) rd_frame++;
`else
            if (t == 6402) check_eq("pat_fb_0_1",  {d_r, d_g, d_b}, WHITE);
            if (t == 6722) check_eq("pat_fb_40_1", {d_r, d_g, d_b}, {10'h3FF, 10'h0, 10'h3FF});
`endif
        end

        check_eq("blank_rise",  blank_rise, 2);
        check_eq("blank_fall",  blank_fall, 1282);
        check_eq("hs_fall",     hs_fall1, 1314);
        check_eq("hs_width",    hs_rise1 - hs_fall1, 192);
        check_eq("line_period", hs_fall2 - hs_fall1, 1600);
        check_eq("vs_fall",     vs_fall, 16002);
        check_eq("vs_width",    vs_rise - vs_fall, 3200);
        check_eq("fs_first",    fs_t1, 22400);
        check_eq("fs_period",   fs_t2 - fs_t1, 22400);
        check_eq("fs_count",    fs_cnt, 2);
        check_eq("full_no_fs",  d_fs_cnt, 0);
        check_eq("full_no_vs",  d_vs_cnt, 0);
`ifndef VGA_SCAN_TEST_PATTERN_EN
        check_eq("rd_per_line",  rd_line1, 640);
        check_eq("rd_per_frame", rd_frame, 5120);
        check_eq("white_vis",    white_cnt, 1280);
        check_eq("dark_blank",   dark_cnt, 320);
`else
        check_eq("pat_no_rd",    rd_any, 0);
`endif

        // Reset in the middle of a line, while sync is active.
        for (int i = 0; i < 2000 && d_hs !== 1'b0; i++) @(negedge clk);
        check_eq("hs_low_seen", d_hs, 1'b0);
        #3 rst = 1'b1;
        #1;
        check_eq("mid_rst_syncs", {d_hs, d_vs, d_blank_n}, 3'b110);
        check_eq("mid_rst_misc",  {d_vclk, d_fs, d_en, d_addr, d_r, d_g, d_b}, 48'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("re_t1", {d_vclk, d_blank_n}, 2'b10);
        @(negedge clk);
        check_eq("re_t2", {d_vclk, d_blank_n}, 2'b01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
